reduction_pipe: RTL and testbench

- Parametrised, pipelined successor to the team's combinational 2-operand lane-reduction unit.
- Splits operands A and B into LANES lanes of LANE_W bits each and sums all 2*LANES lanes.
- Adds a signed/unsigned lane mode, a running accumulator with overflow detection, and valid/ready flow control.
- Sits between the register-file read stage and writeback as a 2-stage pipelined functional unit.

---
 rtl/reduction_pkg.sv | 34 +++
 rtl/lane_adder_tree.sv | 40 ++++
 rtl/reduction_pipe.sv | 136 +++++++++++++
 tb/tb_reduction_pipe.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/reduction_pkg.sv
// Shared helpers for the lane-reduction pipeline.
// Holds lane extension, the exact beat-sum width rule and per-beat control bits.
// Purely declarative: no logic, no latency, no flow control.
package reduction_pkg;

    // Widest lane or sum that ext_lane can extend.
    localparam int EXT_W = 64;

    // Per-beat control carried alongside the lane sums.
    typedef struct packed {
        logic sgn;   // lanes are two's complement
        logic acc;   // add onto the running accumulator
    } beat_ctl_t;

    // Exact width of the sum of 2*lanes values, each lane_w bits wide.
    function automatic int sum_width(input int lane_w, input int lanes);
        return lane_w + $clog2(2 * lanes);
    endfunction

    // Extend the low w bits of value to EXT_W bits, signed or unsigned.
    function automatic logic [EXT_W-1:0] ext_lane(input logic [EXT_W-1:0] value,
                                                  input logic             sgn,
                                                  input int               w);
        logic [EXT_W-1:0] r;
        r = value;
        for (int i = 0; i < EXT_W; i++) begin
            if (i >= w) begin
                r[i] = sgn & value[w-1];
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/lane_adder_tree.sv
// Balanced adder tree summing N lane values of W bits into an exact result.
// Latency: combinational.
// Backpressure: none; the enclosing stage decides when the result is used.
module lane_adder_tree #(
    parameter  int N     = 2,
    parameter  int W     = 9,
    localparam int OUT_W = W + $clog2(N)
) (
    input  logic [N-1:0][W-1:0] in_i,
    input  logic                sgn_i,
    output logic [OUT_W-1:0]    sum_o
);

    localparam int LEVELS = $clog2(N);
    localparam int P      = 1 << LEVELS;
    // Bits above the input width, set when a signed input is negative.
    localparam logic [OUT_W-1:0] HI_MASK = ~OUT_W'({W{1'b1}});

    logic [P-1:0][OUT_W-1:0] work;

    // Extend leaves to full width, then fold pairwise level by level.
    // Padding leaves are zero so they do not disturb a signed sum.
    always_comb begin
        work = '0;
        for (int i = 0; i < N; i++) begin
            work[i] = OUT_W'(in_i[i]);
            if (sgn_i && in_i[i][W-1]) begin
                work[i] = work[i] | HI_MASK;
            end
        end
        for (int span = P / 2; span >= 1; span = span / 2) begin
            for (int j = 0; j < span; j++) begin
                work[j] = work[2*j] + work[2*j+1];
            end
        end
    end

    assign sum_o = work[0];

endmodule

// File: rtl/reduction_pipe.sv
// Sums all lanes of A and B per beat and optionally accumulates, with sticky overflow.
// Latency: 2 cycles (lane sums registered in s1, tree + accumulate registered in s2).
// Backpressure: s2 holds while out_valid && !out_ready; in_ready drops only when s1 cannot drain.
module reduction_pipe
    import reduction_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int LANE_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_a,
    input  logic [DATA_W-1:0] in_b,
    input  logic              in_signed,
    input  logic              in_acc,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_sum,
    output logic              out_ovf
);

    localparam int LANES = DATA_W / LANE_W;
    localparam int SUM_W = sum_width(LANE_W, LANES);
    localparam int PW    = LANE_W + 1;

    if ((DATA_W % LANE_W) != 0) begin : g_chk_lane
        $error("DATA_W must be a multiple of LANE_W");
    end
    if (SUM_W > DATA_W) begin : g_chk_sum
        $error("beat sum width SUM_W exceeds DATA_W");
    end

    typedef struct packed {
        logic [LANES-1:0][PW-1:0] lane_sum;
        beat_ctl_t                ctl;
    } s1_payload_t;

    s1_payload_t       s1_in;
    s1_payload_t       s1_q, s1_d;
    logic              s1_valid_q, s1_valid_d;
    logic              out_valid_q, out_valid_d;
    logic [DATA_W-1:0] out_sum_q, out_sum_d;
    logic              out_ovf_q, out_ovf_d;

    logic              s2_adv, accept, load;
    logic [SUM_W-1:0]  bs;
    logic [DATA_W-1:0] bs_ext;
    logic [DATA_W-1:0] acc_sum;
    logic              carry, sovf, ovf;

    assign s2_adv   = !out_valid_q || out_ready;
    assign in_ready = !s1_valid_q || s2_adv;
    assign accept   = in_valid && in_ready;
    assign load     = s1_valid_q && s2_adv;

    // Stage-1 payload: per-lane pair sums, one bit wider than a lane.
    always_comb begin
        s1_in         = '0;
        s1_in.ctl.sgn = in_signed;
        s1_in.ctl.acc = in_acc;
        for (int i = 0; i < LANES; i++) begin
            s1_in.lane_sum[i] =
                PW'(ext_lane(EXT_W'(in_a[i*LANE_W +: LANE_W]), in_signed, LANE_W)) +
                PW'(ext_lane(EXT_W'(in_b[i*LANE_W +: LANE_W]), in_signed, LANE_W));
        end
    end

    lane_adder_tree #(
        .N (LANES),
        .W (PW)
    ) u_tree (
        .in_i  (s1_q.lane_sum),
        .sgn_i (s1_q.ctl.sgn),
        .sum_o (bs)
    );

    // Accumulate the beat sum; overflow rule follows the beat's own signedness.
    always_comb begin
        bs_ext           = DATA_W'(ext_lane(EXT_W'(bs), s1_q.ctl.sgn, SUM_W));
        {carry, acc_sum} = {1'b0, out_sum_q} + {1'b0, bs_ext};
        sovf             = (out_sum_q[DATA_W-1] == bs_ext[DATA_W-1]) &&
                           (acc_sum[DATA_W-1] != out_sum_q[DATA_W-1]);
        ovf              = s1_q.ctl.sgn ? sovf : carry;
    end

    // Next-state for both stages: s1 fills on accept, s2 loads when it may advance.
    always_comb begin
        s1_d        = s1_q;
        s1_valid_d  = s1_valid_q;
        out_valid_d = out_valid_q;
        out_sum_d   = out_sum_q;
        out_ovf_d   = out_ovf_q;
        if (accept) begin
            s1_d       = s1_in;
            s1_valid_d = 1'b1;
        end else if (load) begin
            s1_valid_d = 1'b0;
        end
        if (load) begin
            out_valid_d = 1'b1;
            if (s1_q.ctl.acc) begin
                out_sum_d = acc_sum;
                out_ovf_d = out_ovf_q | ovf;
            end else begin
                out_sum_d = bs_ext;
                out_ovf_d = 1'b0;
            end
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    // Pipeline registers; reset discards any beat in flight and clears the chain.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_q        <= '0;
            s1_valid_q  <= 1'b0;
            out_valid_q <= 1'b0;
            out_sum_q   <= '0;
            out_ovf_q   <= 1'b0;
        end else begin
            s1_q        <= s1_d;
            s1_valid_q  <= s1_valid_d;
            out_valid_q <= out_valid_d;
            out_sum_q   <= out_sum_d;
            out_ovf_q   <= out_ovf_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_sum   = out_sum_q;
    assign out_ovf   = out_ovf_q;

endmodule

// File: tb/tb_reduction_pipe.sv
// Self-checking bench for reduction_pipe with a queue-based arithmetic reference model.
// Latency: inputs driven after the falling edge, outputs sampled 1 time unit later.
// Backpressure: out_ready is driven directly by the stimulus, including random stalls.
module tb_reduction_pipe;

    localparam int DATA_W = 16;
    localparam int LANE_W = 8;
    localparam int LANES  = DATA_W / LANE_W;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic [DATA_W-1:0] in_a = '0;
    logic [DATA_W-1:0] in_b = '0;
    logic              in_signed = 1'b0;
    logic              in_acc = 1'b0;
    logic              out_valid;
    logic              out_ready = 1'b0;
    logic [DATA_W-1:0] out_sum;
    logic              out_ovf;

    always #5 clk = ~clk;

    reduction_pipe #(.DATA_W(DATA_W), .LANE_W(LANE_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_signed (in_signed),
        .in_acc    (in_acc),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .out_ovf   (out_ovf)
    );

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    // Reference model state: accumulator as a plain integer, results queued in order.
    int          m_acc = 0;
    bit          m_ovf = 1'b0;
    logic [16:0] exp_q[$];

    bit          accepted, consumed;
    logic [15:0] last_sum;
    logic        last_ovf;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Lane values summed as integers; overflow judged by numeric range.
    function automatic void model_beat(input logic [15:0] a, input logic [15:0] b,
                                       input logic s, input logic acc);
        int bs = 0;
        int r;
        bit ov;
        for (int i = 0; i < LANES; i++) begin
            logic [7:0] la, lb;
            la = a[i*8 +: 8];
            lb = b[i*8 +: 8];
            if (s) bs += int'($signed(la)) + int'($signed(lb));
            else   bs += int'(la) + int'(lb);
        end
        if (!acc) begin
            m_acc = bs & 32'hFFFF;
            m_ovf = 1'b0;
        end else begin
            if (s) begin
                int old;
                old = (m_acc >= 32768) ? m_acc - 65536 : m_acc;
                r   = old + bs;
                ov  = (r > 32767) || (r < -32768);
            end else begin
                r  = m_acc + bs;
                ov = (r > 65535);
            end
            m_acc = r & 32'hFFFF;
            m_ovf = m_ovf | ov;
        end
        exp_q.push_back({m_ovf, m_acc[15:0]});
    endfunction

    // One clock: sample handshakes and outputs, update scoreboard, advance to next falling edge.
    task automatic cycle();
        #1;
        accepted = in_valid && in_ready;
        consumed = out_valid && out_ready;
        if (consumed) begin
            last_sum = out_sum;
            last_ovf = out_ovf;
            if (exp_q.size() == 0) begin
                check("spurious_result", out_valid, 0);
            end else begin
                logic [16:0] e;
                e = exp_q.pop_front();
                check("sb_sum", out_sum, e[15:0]);
                check("sb_ovf", out_ovf, e[16]);
            end
        end
        if (accepted) model_beat(in_a, in_b, in_signed, in_acc);
        @(posedge clk);
        cyc++;
        @(negedge clk);
    endtask

    task automatic send(input logic [15:0] a, input logic [15:0] b,
                        input logic s, input logic acc);
        bit ok = 1'b0;
        in_a = a; in_b = b; in_signed = s; in_acc = acc; in_valid = 1'b1;
        for (int n = 0; n < 50; n++) begin
            cycle();
            if (accepted) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) check("accept_timeout", accepted, 1);
        in_valid = 1'b0;
    endtask

    task automatic drain();
        out_ready = 1'b1;
        for (int n = 0; n < 50 && exp_q.size() > 0; n++) cycle();
        check("drain_pending", exp_q.size(), 0);
    endtask

    // Single beat into an empty pipe: no result one cycle on, result the cycle after.
    task automatic beat_expect(input string tag, input logic [15:0] a, input logic [15:0] b,
                               input logic s, input logic acc,
                               input logic [15:0] es, input logic eo);
        out_ready = 1'b1;
        send(a, b, s, acc);
        cycle();
        check({tag, "_early"}, consumed, 0);
        cycle();
        check({tag, "_lat"}, consumed, 1);
        check({tag, "_sum"}, last_sum, es);
        check({tag, "_ovf"}, last_ovf, eo);
    endtask

    function automatic logic [15:0] pick_operand();
        case ($urandom_range(0, 5))
            0:       return 16'h0000;
            1:       return 16'hFFFF;
            2:       return 16'h8080;
            3:       return 16'h7F7F;
            default: return 16'($urandom);
        endcase
    endfunction

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        int na, cons, first_c, last_c;

        // Reset state.
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
        check("rst_out_valid", out_valid, 0);
        check("rst_out_sum", out_sum, 0);
        check("rst_out_ovf", out_ovf, 0);
        check("rst_in_ready", in_ready, 1);
        @(negedge clk);

        // Unsigned and signed lane sums.
        beat_expect("uns", 16'hFF01, 16'h0203, 1'b0, 1'b0, 16'h0105, 1'b0);
        beat_expect("sgn", 16'hFF01, 16'h0203, 1'b1, 1'b0, 16'h0005, 1'b0);
        beat_expect("neg", 16'h8080, 16'h8080, 1'b1, 1'b0, 16'hFE00, 1'b0);

        // Accumulation up to and past unsigned carry-out.
        beat_expect("acc1", 16'hFFFF, 16'hFFFF, 1'b0, 1'b0, 16'h03FC, 1'b0);
        for (int i = 2; i <= 63; i++) send(16'hFFFF, 16'hFFFF, 1'b0, 1'b1);
        drain();
        beat_expect("acc64", 16'hFFFF, 16'hFFFF, 1'b0, 1'b1, 16'hFF00, 1'b0);
        beat_expect("acc65", 16'hFFFF, 16'hFFFF, 1'b0, 1'b1, 16'h02FC, 1'b1);
        beat_expect("acc66", 16'hFFFF, 16'hFFFF, 1'b0, 1'b1, 16'h06F8, 1'b1);
        beat_expect("restart", 16'hFF01, 16'h0203, 1'b0, 1'b0, 16'h0105, 1'b0);

        // Backpressure: only two beats fit while the consumer stalls.
        out_ready = 1'b0;
        na = 0;
        in_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            in_a = 16'($urandom); in_b = 16'($urandom);
            in_signed = 1'($urandom); in_acc = 1'($urandom);
            cycle();
            if (accepted) na++;
        end
        #1;
        check("bp_accepts", na, 2);
        check("bp_in_ready", in_ready, 0);
        check("bp_valid", out_valid, 1);
        check("bp_hold", out_sum, exp_q[0][15:0]);
        cycle();
        check("bp_hold2", out_sum, exp_q[0][15:0]);
        check("bp_in_ready2", in_ready, 0);
        in_valid = 1'b0;
        drain();

        // Streaming: eight back-to-back beats, eight consecutive results.
        out_ready = 1'b1;
        cons = 0; first_c = -1; last_c = -1;
        for (int i = 0; i < 12; i++) begin
            if (i < 8) begin
                in_a = pick_operand(); in_b = pick_operand();
                in_signed = 1'($urandom); in_acc = 1'($urandom);
                in_valid = 1'b1;
            end else begin
                in_valid = 1'b0;
            end
            cycle();
            if (i < 8) check("stream_in_ready", accepted, 1);
            if (consumed) begin
                cons++;
                if (first_c < 0) first_c = cyc;
                last_c = cyc;
            end
        end
        check("stream_count", cons, 8);
        check("stream_span", last_c - first_c, 7);

        // Reset with both stages full.
        out_ready = 1'b0;
        send(16'h1234, 16'h4321, 1'b0, 1'b0);
        send(16'h00FF, 16'h0001, 1'b0, 1'b1);
        #2;
        rst = 1'b1;
        #1;
        check("arst_out_valid", out_valid, 0);
        check("arst_out_sum", out_sum, 0);
        check("arst_out_ovf", out_ovf, 0);
        exp_q.delete();
        m_acc = 0;
        m_ovf = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("arst_in_ready", in_ready, 1);
        @(negedge clk);
        beat_expect("post_rst", 16'h0001, 16'h0000, 1'b0, 1'b1, 16'h0001, 1'b0);

        // Random traffic with random stalls, mixed signedness and chains.
        for (int i = 0; i < 600; i++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 3) != 0);
            in_a      = pick_operand();
            in_b      = pick_operand();
            in_signed = 1'($urandom);
            in_acc    = ($urandom_range(0, 7) != 0);
            cycle();
        end
        in_valid = 1'b0;
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
